cast_rt_scan_ctrl: RTL and testbench

// - Shared multicast route-table lookup engine for one router. Holds a runtime-writable

---
 rtl/cast_rt_scan_ctrl_pkg.sv | 33 +++
 rtl/cast_rt_scan_ctrl_if.sv | 45 ++++
 rtl/cast_rt_scan_ctrl_rr_arb.sv | 35 +++
 rtl/cast_rt_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_cast_rt_scan_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cast_rt_scan_ctrl_pkg.sv
// Shared types and widths for the multicast route-table scan engine.
// Table depth and out-VC mask width come from ROUTE_TABLE_DEPTH and CN.
`ifndef ROUTE_TABLE_DEPTH
`define ROUTE_TABLE_DEPTH 32
`endif
`ifndef CN
`define CN 5
`endif

package cast_rt_pkg;

  localparam int ID_W       = 10;
  localparam int CN         = `CN;
  localparam int RT_DEPTH   = `ROUTE_TABLE_DEPTH;
  localparam int RT_ENTRY_W = 1 + ID_W + CN;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESP
  } scan_state_t;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
    logic [CN-1:0]   vc;
  } rt_entry_t;

  function automatic int rr_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cast_rt_scan_ctrl_if.sv
// Request/response and table-config bundle for cast_rt_scan_ctrl.
// master = requesters and config agent, slave = lookup engine.
interface cast_rt_scan_ctrl_if #(
  parameter int NREQ  = 5,
  parameter int DEPTH = 32
);
  import cast_rt_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*ID_W-1:0]  req_stream_id;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic                  rsp_hit;
  logic [CN-1:0]         rsp_vc;
  logic                  cfg_we;
  logic [AW-1:0]         cfg_addr;
  logic [RT_ENTRY_W-1:0] cfg_entry;

  modport master (
    output req_valid,
    output req_stream_id,
    output cfg_we,
    output cfg_addr,
    output cfg_entry,
    input  req_ready,
    input  rsp_valid,
    input  rsp_hit,
    input  rsp_vc
  );

  modport slave (
    input  req_valid,
    input  req_stream_id,
    input  cfg_we,
    input  cfg_addr,
    input  cfg_entry,
    output req_ready,
    output rsp_valid,
    output rsp_hit,
    output rsp_vc
  );

endinterface

// File: rtl/cast_rt_scan_ctrl_rr_arb.sv
// Round-robin arbiter: first request at or after ptr_i, wrapping at NREQ.
// Produces a one-hot grant plus its binary index.
module cast_rr_arb #(
  parameter int NREQ = 5,
  parameter int PW   = 3
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o,
  output logic            any_o
);

  int          t;
  logic [PW-1:0] j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    t     = 0;
    j     = '0;
    for (int i = 0; i < NREQ; i++) begin
      t = int'(ptr_i) + i;
      if (t >= NREQ) t = t - NREQ;
      j = PW'(t);
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/cast_rt_scan_ctrl.sv
// Shared multicast route-table lookup: RR grant, then one entry per cycle.
// CAST_RT_EARLY_EXIT_EN: stop the scan on the first hit (else fixed latency).
module cast_rt_scan_ctrl
  import cast_rt_pkg::*;
#(
  parameter int NREQ  = 5,
  parameter int DEPTH = RT_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  cast_rt_scan_ctrl_if.slave  bus,
  output logic                busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  scan_state_t     state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            hit_q, hit_d;
  logic [CN-1:0]   vc_q, vc_d;

  logic [DEPTH-1:0] vld_q;
  logic [ID_W-1:0]  tid_q [DEPTH];
  logic [CN-1:0]    tvc_q [DEPTH];

  rt_entry_t       wr_e;
  logic [NREQ-1:0] arb_gnt;
  logic [PW-1:0]   arb_idx;
  logic            arb_any;
  logic [NREQ-1:0] req_rdy;
  logic [NREQ-1:0] rsp_v;
  logic            match;
  logic            last;

  cast_rr_arb #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign wr_e = rt_entry_t'(bus.cfg_entry);

  // Only the valid bits need reset; payload is don't-care when invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (bus.cfg_we) begin
      vld_q[bus.cfg_addr] <= wr_e.vld;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && bus.cfg_we) begin
      tid_q[bus.cfg_addr] <= wr_e.id;
      tvc_q[bus.cfg_addr] <= wr_e.vc;
    end
  end

  assign match = vld_q[addr_q] && (tid_q[addr_q] == id_q);
  assign last  = (addr_q == AW'(DEPTH - 1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    addr_d  = addr_q;
    hit_d   = hit_q;
    vc_d    = vc_q;
    req_rdy = '0;
    rsp_v   = '0;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          req_rdy = arb_gnt;
          gnt_d   = arb_idx;
          id_d    = bus.req_stream_id[int'(arb_idx)*ID_W +: ID_W];
          addr_d  = '0;
          hit_d   = 1'b0;
          vc_d    = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (match && !hit_q) begin
          hit_d = 1'b1;
          vc_d  = tvc_q[addr_q];
        end
        if (!last) addr_d = addr_q + 1'b1;
`ifdef CAST_RT_EARLY_EXIT_EN
        if (last || match) state_d = RESP;
`else
        if (last) state_d = RESP;
`endif
      end
      RESP: begin
        rsp_v[gnt_q] = 1'b1;
        ptr_d        = PW'(rr_inc(int'(gnt_q), NREQ));
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      id_q    <= '0;
      addr_q  <= '0;
      hit_q   <= 1'b0;
      vc_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      hit_q   <= hit_d;
      vc_q    <= vc_d;
    end
  end

  // Outputs forced low while reset is held so a mid-scan reset emits nothing.
  assign bus.req_ready = rst ? '0 : req_rdy;
  assign bus.rsp_valid = rst ? '0 : rsp_v;
  assign bus.rsp_hit   = !rst && (state_q == RESP) && hit_q;
  assign bus.rsp_vc    = (!rst && state_q == RESP) ? vc_q : '0;
  assign busy          = !rst && (state_q != IDLE);

endmodule

// File: tb/tb_cast_rt_scan_ctrl.sv
// Directed bench for cast_rt_scan_ctrl (DEPTH=32, NREQ=5, CN=5).
// Expected latencies follow CAST_RT_EARLY_EXIT_EN.
module tb_cast_rt_scan_ctrl;
  import cast_rt_pkg::*;

  localparam int NREQ  = 5;
  localparam int DEPTH = 32;
`ifdef CAST_RT_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  cast_rt_scan_ctrl_if #(.NREQ(NREQ), .DEPTH(DEPTH)) rif ();

  cast_rt_scan_ctrl #(
    .NREQ  (NREQ),
    .DEPTH (DEPTH)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (rif.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input int a, input logic v,
                        input logic [ID_W-1:0] id,
                        input logic [CN-1:0] vc);
    rif.cfg_we    = 1'b1;
    rif.cfg_addr  = 5'(a);
    rif.cfg_entry = {v, id, vc};
    tick();
    rif.cfg_we    = 1'b0;
  endtask

  task automatic do_lookup(input int p, input logic [ID_W-1:0] id,
                           output logic [NREQ-1:0] rdy,
                           output logic [NREQ-1:0] rv,
                           output logic h, output logic [CN-1:0] v,
                           output int lat);
    int t0;
    int n;
    rif.req_valid[p] = 1'b1;
    rif.req_stream_id[p*ID_W +: ID_W] = id;
    @(negedge clk);
    rdy = rif.req_ready;
    t0  = cyc;
    tick();
    rif.req_valid[p] = 1'b0;
    rv = '0; h = 1'b0; v = '0; lat = -1; n = 0;
    while (n < 60 && lat < 0) begin
      @(negedge clk);
      n++;
      if (|rif.rsp_valid) begin
        rv  = rif.rsp_valid;
        h   = rif.rsp_hit;
        v   = rif.rsp_vc;
        lat = cyc - t0;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rif.req_valid = '1;
    tick();
    tick();
    @(negedge clk);
    total++;
    if (rif.req_ready !== 5'b0) begin
      bad++; $display("FAIL reset_ready got=%b want=00000", rif.req_ready);
    end
    total++;
    if (rif.rsp_valid !== 5'b0) begin
      bad++; $display("FAIL reset_rsp_valid got=%b want=00000", rif.rsp_valid);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy got=%b want=0", busy);
    end
    total++;
    if ({rif.rsp_hit, rif.rsp_vc} !== 6'b0) begin
      bad++; $display("FAIL reset_hit_vc got=%b want=000000", {rif.rsp_hit, rif.rsp_vc});
    end
    tick();
    rif.req_valid = '0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] g;
    logic [NREQ-1:0] want;
    int n;
    for (int p = 0; p < NREQ; p++)
      rif.req_stream_id[p*ID_W +: ID_W] = 10'h100 + 10'(p);
    rif.req_valid = '1;
    for (int k = 0; k < 6; k++) begin
      want = 5'b00001 << (k % NREQ);
      n = 0;
      do begin
        @(negedge clk); n++;
      end while (!(|rif.req_ready) && n < 60);
      g = rif.req_ready;
      total++;
      if (g !== want) begin
        bad++; $display("FAIL fair_grant%0d got=%b want=%b", k, g, want);
      end
      n = 0;
      do begin
        @(negedge clk); n++;
      end while (!(|rif.rsp_valid) && n < 60);
      total++;
      if (rif.rsp_valid !== want || rif.rsp_hit !== 1'b0) begin
        bad++; $display("FAIL fair_rsp%0d got=%b hit=%b want=%b hit=0",
                        k, rif.rsp_valid, rif.rsp_hit, want);
      end
    end
    tick();
    rif.req_valid = '0;
    tick();
  endtask

  task automatic test_lookup();
    logic [NREQ-1:0] rdy, rv;
    logic h;
    logic [CN-1:0] v;
    int lat;
    cfg_wr(3, 1'b1, 10'h2A, 5'b00101);
    do_lookup(1, 10'h2A, rdy, rv, h, v, lat);
    total++;
    if (rdy !== 5'b00010) begin
      bad++; $display("FAIL lookup_ready got=%b want=00010", rdy);
    end
    total++;
    if (rv !== 5'b00010 || h !== 1'b1) begin
      bad++; $display("FAIL lookup_rsp got=%b hit=%b want=00010 hit=1", rv, h);
    end
    total++;
    if (v !== 5'b00101) begin
      bad++; $display("FAIL lookup_vc got=%b want=00101", v);
    end
    total++;
    if (lat !== (EARLY ? 5 : 33)) begin
      bad++; $display("FAIL lookup_lat got=%0d want=%0d", lat, EARLY ? 5 : 33);
    end
  endtask

  task automatic test_miss();
    logic [NREQ-1:0] rdy, rv;
    logic h;
    logic [CN-1:0] v;
    int lat;
    do_lookup(0, 10'h011, rdy, rv, h, v, lat);
    total++;
    if (rdy !== 5'b00001 || rv !== 5'b00001) begin
      bad++; $display("FAIL miss_port got=%b/%b want=00001/00001", rdy, rv);
    end
    total++;
    if (h !== 1'b0 || v !== 5'b0) begin
      bad++; $display("FAIL miss_result got=%b/%b want=0/00000", h, v);
    end
    total++;
    if (lat !== 33) begin
      bad++; $display("FAIL miss_lat got=%0d want=33", lat);
    end
  endtask

  task automatic test_duplicates();
    logic [NREQ-1:0] rdy, rv;
    logic h;
    logic [CN-1:0] v;
    int lat;
    cfg_wr(7, 1'b1, 10'h3FF, 5'b10000);
    cfg_wr(2, 1'b1, 10'h3FF, 5'b00010);
    do_lookup(2, 10'h3FF, rdy, rv, h, v, lat);
    total++;
    if (rv !== 5'b00100 || h !== 1'b1) begin
      bad++; $display("FAIL dup_rsp got=%b hit=%b want=00100 hit=1", rv, h);
    end
    total++;
    if (v !== 5'b00010) begin
      bad++; $display("FAIL dup_vc got=%b want=00010", v);
    end
    total++;
    if (lat !== (EARLY ? 4 : 33)) begin
      bad++; $display("FAIL dup_lat got=%0d want=%0d", lat, EARLY ? 4 : 33);
    end
  endtask

  task automatic test_write_during_scan();
    logic [NREQ-1:0] rdy, rv;
    logic h;
    logic [CN-1:0] v;
    int lat, t0, n;
    rif.req_valid[3] = 1'b1;
    rif.req_stream_id[3*ID_W +: ID_W] = 10'h155;
    @(negedge clk);
    t0 = cyc;
    total++;
    if (rif.req_ready !== 5'b01000) begin
      bad++; $display("FAIL wscan_ready got=%b want=01000", rif.req_ready);
    end
    tick();
    rif.req_valid[3] = 1'b0;
    tick();
    tick();
    rif.cfg_we    = 1'b1;
    rif.cfg_addr  = 5'd5;
    rif.cfg_entry = {1'b1, 10'h155, 5'b01000};
    tick();
    rif.cfg_we = 1'b0;
    tick();
    tick();
    rif.cfg_we    = 1'b1;
    rif.cfg_entry = {1'b0, 10'h155, 5'b01000};
    tick();
    rif.cfg_we = 1'b0;
    rv = '0; h = 1'b0; v = '0; lat = -1; n = 0;
    while (n < 60 && lat < 0) begin
      @(negedge clk);
      n++;
      if (|rif.rsp_valid) begin
        rv = rif.rsp_valid; h = rif.rsp_hit; v = rif.rsp_vc; lat = cyc - t0;
      end
    end
    tick();
    total++;
    if (rv !== 5'b01000 || h !== 1'b1 || v !== 5'b01000) begin
      bad++; $display("FAIL wscan_hit got=%b/%b/%b want=01000/1/01000", rv, h, v);
    end
    total++;
    if (lat !== (EARLY ? 7 : 33)) begin
      bad++; $display("FAIL wscan_lat got=%0d want=%0d", lat, EARLY ? 7 : 33);
    end
    do_lookup(3, 10'h155, rdy, rv, h, v, lat);
    total++;
    if (rv !== 5'b01000 || h !== 1'b0 || v !== 5'b0 || lat !== 33) begin
      bad++; $display("FAIL wscan_inval got=%b/%b/%b lat=%0d want=01000/0/00000 lat=33",
                      rv, h, v, lat);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [NREQ-1:0] rdy, rv;
    logic h;
    logic [CN-1:0] v;
    int lat, seen;
    rif.req_valid[4] = 1'b1;
    rif.req_stream_id[4*ID_W +: ID_W] = 10'h2A;
    @(negedge clk);
    total++;
    if (rif.req_ready !== 5'b10000) begin
      bad++; $display("FAIL rmid_ready got=%b want=10000", rif.req_ready);
    end
    tick();
    rif.req_valid[4] = 1'b0;
    tick();
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL rmid_busy got=%b want=1", busy);
    end
    tick();
    rst = 1'b1;
    rif.cfg_we    = 1'b1;
    rif.cfg_addr  = 5'd9;
    rif.cfg_entry = {1'b1, 10'h2A, 5'b11111};
    tick();
    rst = 1'b0;
    rif.cfg_we = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (|rif.rsp_valid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL rmid_no_rsp got=%0d want=0", seen);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL rmid_idle got=%b want=0", busy);
    end
    tick();
    do_lookup(4, 10'h2A, rdy, rv, h, v, lat);
    total++;
    if (rv !== 5'b10000 || h !== 1'b0 || v !== 5'b0 || lat !== 33) begin
      bad++; $display("FAIL rmid_miss got=%b/%b/%b lat=%0d want=10000/0/00000 lat=33",
                      rv, h, v, lat);
    end
  endtask

  initial begin
    rst               = 1'b1;
    rif.req_valid     = '0;
    rif.req_stream_id = '0;
    rif.cfg_we        = 1'b0;
    rif.cfg_addr      = '0;
    rif.cfg_entry     = '0;
    test_reset();
    test_fairness();
    test_lookup();
    test_miss();
    test_duplicates();
    test_write_during_scan();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
